// File: rtl/rk8e_break_bridge.sv
// RK8-E data-break bridge: buffers disk-to-memory words in a small FIFO and
// runs one CPU break cycle per word. RK8E_DMA_LATE_EN adds a late-grant watchdog.
module rk8e_break_bridge #(
    parameter int DEPTH       = 4,
    parameter int LATE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        dmaREQ,
    input  logic        dmaRD,
    input  logic        dmaWR,
    input  logic [14:0] dmaADDR,
    input  logic [11:0] dmaDOUT,
    output logic [11:0] dmaDIN,
    output logic        dmaGNT,
    output logic        data_break,
    input  logic        break_in_prog,
    input  logic        break_done,
    output logic [14:0] brk_addr,
    output logic [11:0] brk_wdata,
    output logic        brk_write,
    input  logic [11:0] mem_rdata,
    output logic        fifo_empty,
    output logic        dma_late
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("rk8e_break_bridge: DEPTH must be a power of two in 2..16");
    end
    if (LATE_CYCLES < 1) begin : g_bad_late
        $error("rk8e_break_bridge: LATE_CYCLES must be at least 1");
    end

    // state   | meaning
    // S_IDLE  | pick next job: buffered write first, then a pending read
    // S_REQ   | data_break raised, waiting for break_in_prog
    // S_BRK   | CPU in break cycle, waiting for break_done
    // S_RRET  | read data latched, grant the disk next
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_BRK, S_RRET} state_t;

    state_t      state;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [14:0] fifo_addr [DEPTH];
    logic [11:0] fifo_data [DEPTH];
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic        rd_req;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign pop    = (state == S_BRK) && break_done && brk_write && !clear;
    // dmaGNT high means the disk is still showing the request just granted
    assign push   = dmaREQ && dmaWR && !dmaGNT && (!fifo_full || pop) && !clear;
    assign rd_req = dmaREQ && dmaRD && !dmaWR && !dmaGNT;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[AW-1:0]] <= dmaADDR;
            fifo_data[wr_ptr[AW-1:0]] <= dmaDOUT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            data_break <= 1'b0;
            dmaGNT     <= 1'b0;
            dmaDIN     <= '0;
            brk_addr   <= '0;
            brk_wdata  <= '0;
            brk_write  <= 1'b0;
        end else if (clear) begin
            state      <= S_IDLE;
            data_break <= 1'b0;
            dmaGNT     <= 1'b0;
        end else begin
            dmaGNT <= push;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        brk_addr   <= fifo_addr[rd_ptr[AW-1:0]];
                        brk_wdata  <= fifo_data[rd_ptr[AW-1:0]];
                        brk_write  <= 1'b1;
                        data_break <= 1'b1;
                        state      <= S_REQ;
                    end else if (rd_req) begin
                        brk_addr   <= dmaADDR;
                        brk_write  <= 1'b0;
                        data_break <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (break_in_prog) begin
                        data_break <= 1'b0;
                        state      <= S_BRK;
                    end
                end
                S_BRK: begin
                    if (break_done) begin
                        if (brk_write) begin
                            state <= S_IDLE;
                        end else begin
                            dmaDIN <= mem_rdata;
                            state  <= S_RRET;
                        end
                    end
                end
                S_RRET: begin
                    dmaGNT <= 1'b1;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RK8E_DMA_LATE_EN
    localparam int LW = $clog2(LATE_CYCLES + 1);

    logic [LW-1:0] late_cnt;

    // counter idles at zero outside REQ, so every REQ entry starts a fresh count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            late_cnt <= '0;
            dma_late <= 1'b0;
        end else if (clear) begin
            late_cnt <= '0;
            dma_late <= 1'b0;
        end else if (state == S_REQ) begin
            if (late_cnt != LW'(LATE_CYCLES))
                late_cnt <= late_cnt + LW'(1);
            if (late_cnt == LW'(LATE_CYCLES - 1))
                dma_late <= 1'b1;
        end else begin
            late_cnt <= '0;
        end
    end
`else
    assign dma_late = 1'b0;
`endif

endmodule

// File: doc/rk8e_break_bridge.md
# rk8e_break_bridge

Data-break bridge between the RK8-E disk controller's DMA port (`dmaREQ`/`dmaRD`/`dmaWR`/`dmaADDR`) and the CPU's data-break memory cycle. It buffers disk-to-memory words in a small FIFO so SD transfers are not stalled by CPU instruction timing. It raises `data_break`, follows the CPU break handshake, and performs one 12-bit memory read or write per break. Memory-to-disk reads are single-outstanding and strictly ordered behind buffered writes.

## Interface
- `DEPTH`, 4: write-FIFO entries (power of two, 2..16); each entry is 15-bit address + 12-bit data.
- `LATE_CYCLES`, 1024: break-grant watchdog limit; used only with `DMA_LATE_EN`.

- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-low reset.
- `clear` input 1: synchronous IOCLR/CAF flush, active high.
- `dmaREQ` input 1: disk requests a word transfer (level).
- `dmaRD` input 1: request is memory→disk; qualified by `dmaREQ`.
- `dmaWR` input 1: request is disk→memory; qualified by `dmaREQ`.
- `dmaADDR` input [0:14]: 15-bit memory address, field bits 0:2.
- `dmaDOUT` input [0:11]: word from disk to memory.
- `dmaDIN` output [0:11]: word from memory to disk; valid when `dmaGNT` pulses on a read.
- `dmaGNT` output 1: one-cycle accept pulse for the current request.
- `data_break` output 1: break request to the CPU.
- `break_in_prog` input 1: CPU has entered the break cycle.
- `break_done` input 1: one-cycle pulse. `mem_rdata` is valid this cycle and the write is committed.
- `brk_addr` output [0:14]: break address.
- `brk_wdata` output [0:11]: break write data.
- `brk_write` output 1: 1 = memory write, 0 = memory read.
- `mem_rdata` input [0:11]: memory read data.
- `fifo_empty` output 1: no buffered writes pending.
- `dma_late` output 1: sticky late-break flag (see Configuration).

## Operation
- **Request acceptance**
  - Write: accepted when `dmaREQ & dmaWR` and the FIFO is not full, or is full and popping in the same cycle. Acceptance pushes {`dmaADDR`, `dmaDOUT`} and pulses `dmaGNT`.
  - Read: accepted only in IDLE with the FIFO empty. The bridge latches `dmaADDR` and does not grant until data returns.
  - `dmaRD` and `dmaWR` both high: treated as a write.
  - `dmaGNT` never pulses twice for one request. The disk drops or changes `dmaREQ` the cycle after the grant, so the bridge ignores the request in the cycle following any grant.
- **FSM states**
  - IDLE: if the FIFO is non-empty, load `brk_*` from the FIFO head and go to REQ. Otherwise, on a pending read, load the read address with `brk_write`=0 and go to REQ.
  - REQ: `data_break`=1. On `break_in_prog`=1, go to BRK.
  - BRK: `data_break`=0. On `break_done`:
    - write: pop the FIFO, go to IDLE.
    - read: latch `mem_rdata` into `dmaDIN`, go to RRET.
  - RRET: pulse `dmaGNT` for 1 cycle, go to IDLE.
- **Ordering**
  - Memory sees writes in acceptance order.
  - A read is never issued while the FIFO is non-empty, so a read-after-write to the same address returns the new data.
- **`clear`**
  - Empties the FIFO, forces IDLE, drops `data_break`, and cancels any pending read without a grant.
  - A `break_done` arriving after `clear` is ignored.
  - `clear` overrides a simultaneous push.
- **Full-width pointers**: `DEPTH` entries plus 1-bit wrap, so full and empty are distinguishable; pointers wrap modulo `DEPTH`.

## Timing
- **Reset values**: `dmaGNT`=0, `data_break`=0, `dmaDIN`=0, `brk_addr`=0, `brk_wdata`=0, `brk_write`=0, `fifo_empty`=1, `dma_late`=0, FSM=IDLE. FIFO pointers are zero.
- **Write grant**: registered, asserted the cycle after `dmaREQ & dmaWR` is sampled with space available.
- **Break request**: `data_break` rises 1 cycle after entering IDLE with work, i.e. 2 cycles after the first write is accepted into an empty FIFO.
- **Read latency**: `dmaGNT` pulses 2 cycles after `break_done`, with `dmaDIN` valid on that cycle and held until the next read.
- **`brk_*` outputs**: stable from REQ entry through `break_done`.
- **Throughput**: one break per 3 + CPU-latency cycles. A push and a pop may occur in the same cycle.

## Configuration
- `RK8E_DMA_LATE_EN` defined:
  - A counter clears on REQ entry and increments each REQ cycle.
  - Reaching `LATE_CYCLES` sets `dma_late` (sticky; cleared only by `reset` or `clear`) for RK8-E status bit 9.
  - The request stays asserted.
- Not defined: `dma_late` is tied to 0 and no counter is built.

## Test plan
- **Single write**: reset, `dmaREQ`/`dmaWR`, `dmaADDR`=15'o01234, `dmaDOUT`=12'o7654 → `dmaGNT` next cycle. `data_break` rises, then `brk_addr`=01234, `brk_wdata`=7654, `brk_write`=1. After `break_done`, `fifo_empty`=1.
- **FIFO full**: hold `break_in_prog`=0 and stream 6 writes → exactly 4 grants, then stall. Release breaks → all 6 words reach memory in order and the remaining 2 are granted as space frees.
- **Read after write**: write 12'o0077 to 15'o00100, then read 15'o00100 → the read break is issued only after the write pops. `mem_rdata`=0077 is returned on `dmaDIN` with `dmaGNT` 2 cycles after `break_done`.
- **Clear mid-operation**: 3 writes buffered and the FSM in BRK, assert `clear` → `data_break`=0, `fifo_empty`=1. A following `break_done` causes no grant and no state change.
- **Async reset**: drop `reset` mid-REQ → all outputs go to their reset values immediately, without waiting for a clock edge.
- **With `RK8E_DMA_LATE_EN` and `LATE_CYCLES`=8**: hold off `break_in_prog` for 8 cycles → `dma_late`=1 and stays 1 after the break completes. `clear` → 0.
